stopwatch_bcd_n: RTL
====================

Name: stopwatch_bcd_n

Overview:
Parametrised multi-digit BCD stopwatch, the successor to the fixed two-digit counter.
- Counts prescaled clock ticks across DIGITS cascaded decimal digits.
- Explicit start/stop/clear control and selectable saturate-or-wrap at full scale.
- Feeds the display/decoder stage; all digits are presented as one packed bus.

Parameters:
DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
TICK_DIV, 1, clock cycles per count increment (1..65535); 1 = count every cycle.
SATURATE, 1, 1: hold at all-9s on overflow; 0: wrap to all-0s and continue.

Ports:
clk  input  1  clock; all state changes on the falling edge of clk.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  single-cycle pulse: begin/resume counting.
stop  input  1  single-cycle pulse: pause counting (value held).
clear  input  1  single-cycle pulse: zero count and prescaler, return to IDLE.
lap  input  1  lap toggle (only with optional feature).
digits_out  output  4*DIGITS  displayed BCD value, digit k at [4k+3:4k].
running  output  1  high in RUN state.
overflow  output  1  sticky; set on full-scale rollover/saturation, cleared by clear or reset.
lap_active  output  1  high while display is frozen on a lap value.

Behaviour:
- Clock and reset: one clock, falling-edge active. Reset is asynchronous, active-low.
- Reset values: count=0, prescaler=0, state=IDLE, digits_out=0, running=0, overflow=0, lap_active=0.
- States and transitions:
  - IDLE: start->RUN.
  - RUN: stop->PAUSE; full-scale increment with SATURATE=1 ->SAT.
  - PAUSE: start->RUN.
  - SAT: only clear leaves it (->IDLE).
- clear from any state ->IDLE, same edge.
- Simultaneous pulses: priority clear > stop > start. start+stop in RUN -> PAUSE; start+stop in PAUSE/IDLE -> RUN ignored, stop wins (state unchanged).
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN. Holds value in PAUSE.
  - Zeroed by clear and on the IDLE->RUN transition only; resume from PAUSE continues the partial period.
- Increment:
  - Occurs on the edge where state=RUN and prescaler==TICK_DIV-1; TICK_DIV=1 -> every RUN edge.
  - The edge that enters RUN does not increment; the first increment is TICK_DIV edges after the start edge.
- BCD arithmetic:
  - Digit k increments when all lower digits are 9 and an increment occurs.
  - A digit at 9 goes to 0 with carry.
  - Digits never hold values 10..15.
- Full scale (all digits 9) plus an increment:
  - SATURATE=1: value stays all-9s, overflow<=1, state->SAT, running<=0.
  - SATURATE=0: value becomes 0, overflow<=1, state stays RUN.
- Output timing: digits_out is the count register, registered, zero extra latency; the new value is visible after the incrementing edge.
- running is a registered decode of state (updates with the state edge).
- stop on the same edge as an increment: the increment completes, then PAUSE.
- clear on the same edge as an increment: result 0, overflow 0.
- Reset mid-count: immediate asynchronous return to reset values regardless of clk.

Optional Feature:
STOPWATCH_LAP_EN.
- Defined:
  - A lap pulse in RUN or PAUSE with lap_active=0 copies the live count into a lap register and sets lap_active=1. digits_out then shows the lap register while counting continues underneath.
  - A lap pulse with lap_active=1 clears lap_active; digits_out returns to the live count on the next edge.
  - lap is ignored in IDLE and SAT.
  - clear forces lap_active=0.
  - Priority: clear > lap; lap is independent of start/stop.
- Not defined: lap input unused, no lap register, lap_active tied 0, digits_out always live.

Test Plan:
1. DIGITS=2,TICK_DIV=1: reset, start pulse, run 12 edges -> digits_out=8'h12, running=1, overflow=0.
2. DIGITS=2,TICK_DIV=3: start, 7 edges -> count=2 (increments on edges 3 and 6). Stop on edge 7, 5 idle edges, start -> next increment 2 edges later (partial period retained), count=3.
3. DIGITS=2,SATURATE=1: run from 0 for 100 increments -> digits_out=8'h99, overflow=1, running=0. Further start pulses ignored; clear -> 8'h00, overflow=0, IDLE.
4. DIGITS=2,SATURATE=0: 100 increments -> digits_out=8'h00, overflow=1, still running; 5 more -> 8'h05.
5. start+stop same edge in RUN at count 8'h07 -> PAUSE, count holds 8'h07. clear+start same edge -> IDLE, 8'h00. rst_n low between clk edges -> outputs 0 immediately.
6. STOPWATCH_LAP_EN, TICK_DIV=1: lap at count 8'h25 -> digits_out holds 8'h25 for 10 edges, lap_active=1. Second lap -> digits_out=8'h36 live, lap_active=0.

Source files
------------

// File: rtl/stopwatch_bcd_n.sv
// stopwatch_bcd_n: DIGITS-digit BCD stopwatch on the falling clock edge, with start/stop/clear control.
// Define STOPWATCH_LAP_EN to add the lap-hold display register.
module stopwatch_bcd_n #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1,
  parameter bit SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic                  running,
  output logic                  overflow,
  output logic                  lap_active
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, SAT} state_t;

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  state_t              state, state_nx;
  logic [15:0]         presc, presc_nx;
  logic [4*DIGITS-1:0] count, count_nx, count_inc;
  logic                overflow_nx;
  logic                full;
  logic                tick;

  // Ripple-carry BCD increment; digits at 9 roll to 0 and pass the carry up.
  always_comb begin : bcd_inc
    logic carry;
    carry     = 1'b1;
    full      = 1'b1;
    count_inc = count;
    for (int k = 0; k < DIGITS; k++) begin
      if (count[4*k +: 4] != 4'd9) full = 1'b0;
      if (carry) begin
        if (count[4*k +: 4] == 4'd9) begin
          count_inc[4*k +: 4] = 4'd0;
        end else begin
          count_inc[4*k +: 4] = count[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign tick = (state == RUN) && (presc == PRESC_LAST);

  always_comb begin
    state_nx    = state;
    presc_nx    = presc;
    count_nx    = count;
    overflow_nx = overflow;
    if (clear) begin
      state_nx    = IDLE;
      presc_nx    = '0;
      count_nx    = '0;
      overflow_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state_nx = RUN;
            presc_nx = '0;
          end
        end
        PAUSE: begin
          if (start && !stop) state_nx = RUN;
        end
        RUN: begin
          presc_nx = tick ? 16'd0 : presc + 16'd1;
          if (tick) begin
            if (!full) begin
              count_nx = count_inc;
            end else if (SATURATE) begin
              overflow_nx = 1'b1;
              state_nx    = SAT;
            end else begin
              count_nx    = '0;
              overflow_nx = 1'b1;
            end
          end
          // A saturating increment wins over a coincident stop.
          if (stop && state_nx == RUN) state_nx = PAUSE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      count    <= count_nx;
      overflow <= overflow_nx;
      running  <= (state_nx == RUN);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [4*DIGITS-1:0] lap_reg;
  logic                lap_q;

  // Lap toggles a frozen copy of the live count onto the display.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_reg <= '0;
      lap_q   <= 1'b0;
    end else if (clear) begin
      lap_q <= 1'b0;
    end else if (lap && (state == RUN || state == PAUSE)) begin
      if (!lap_q) begin
        lap_reg <= count;
        lap_q   <= 1'b1;
      end else begin
        lap_q <= 1'b0;
      end
    end
  end

  assign lap_active = lap_q;
  assign digits_out = lap_q ? lap_reg : count;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign lap_active = 1'b0;
  assign digits_out = count;
`endif

endmodule
